// File: rtl/kv_cache_pkg.sv
// kv_cache_pkg: shared op/status/state encodings for the key/value
// store command front-end.
package kv_cache_pkg;

   typedef enum logic [1:0] {
      OP_GET  = 2'd0,
      OP_PUT  = 2'd1,
      OP_DEL  = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK   = 2'd0,
      ST_MISS = 2'd1,
      ST_FULL = 2'd2,
      ST_ERR  = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_EXEC   = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   localparam int EMPTY_KEY = 0;

endpackage

// File: rtl/kv_cache_controller_kv_match_encoder.sv
// kv_match_encoder: any-set flag plus lowest-set index of a vector.
// Pure combinational; used for both hit and free-cell selection.
module kv_match_encoder #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec,
   output logic          any,
   output logic [IW-1:0] idx
);

   always_comb begin
      any = |vec;
      idx = '0;
      // Scan downward so the lowest set bit is the last assignment.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/kv_cache_controller.sv
// kv_cache_controller: GET/PUT/DEL command front-end for the cell array.
// Optional round-robin eviction on a full store: define KV_CACHE_EVICT_EN.
module kv_cache_controller
   import kv_cache_pkg::*;
#(
   parameter int NUM_CELLS   = 4,
   parameter int KEY_WIDTH   = 8,
   parameter int VALUE_WIDTH = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [KEY_WIDTH-1:0]           cmd_key,
   input  logic [VALUE_WIDTH-1:0]         cmd_value,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [1:0]                     rsp_status,
   output logic [VALUE_WIDTH-1:0]         rsp_value,
   output logic [NUM_CELLS-1:0]           cell_write_op,
   output logic [NUM_CELLS-1:0]           cell_read_op,
   output logic [KEY_WIDTH-1:0]           cell_key_in,
   output logic [VALUE_WIDTH-1:0]         cell_value_in,
   input  logic [NUM_CELLS*KEY_WIDTH-1:0] cell_key_out,
   input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_value_out,
   input  logic [NUM_CELLS-1:0]           cell_used
);

   localparam int IW = $clog2(NUM_CELLS);
   localparam logic [NUM_CELLS-1:0] ONE = NUM_CELLS'(1);

   state_e                 state_q, state_d;
   op_e                    op_q;
   logic [KEY_WIDTH-1:0]   key_q;
   logic [VALUE_WIDTH-1:0] value_q;

   logic [NUM_CELLS-1:0]   hit_vec, free_vec;
   logic                   hit_any, free_any;
   logic [IW-1:0]          hit_idx, free_idx;
   logic                   hit_q, free_q;
   logic [IW-1:0]          hit_idx_q, free_idx_q;

   status_e                status_q, status_d;
   logic [VALUE_WIDTH-1:0] rval_q, rval_d;
   logic                   accept;

`ifdef KV_CACHE_EVICT_EN
   logic [IW-1:0]          victim_q;
   logic                   evict;
`endif

   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      for (int i = 0; i < NUM_CELLS; i++) begin
         hit_vec[i] = cell_used[i] &&
            (cell_key_out[i*KEY_WIDTH +: KEY_WIDTH] == key_q);
      end
      free_vec = ~cell_used;
   end

   kv_match_encoder #(.N(NUM_CELLS), .IW(IW)) u_hit_enc (
      .vec (hit_vec),
      .any (hit_any),
      .idx (hit_idx)
   );

   kv_match_encoder #(.N(NUM_CELLS), .IW(IW)) u_free_enc (
      .vec (free_vec),
      .any (free_any),
      .idx (free_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      cmd_ready     = 1'b0;
      rsp_valid     = 1'b0;
      cell_write_op = '0;
      cell_read_op  = '0;
      cell_key_in   = '0;
      cell_value_in = '0;
      status_d      = status_q;
      rval_d        = rval_q;
`ifdef KV_CACHE_EVICT_EN
      evict         = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            cell_read_op = '1;
            state_d      = S_EXEC;
         end
         S_EXEC: begin
            state_d  = S_RESP;
            rval_d   = '0;
            status_d = ST_OK;
            if (op_q == OP_RSVD ||
                key_q == KEY_WIDTH'(EMPTY_KEY)) begin
               status_d = ST_ERR;
            end else begin
               unique case (op_q)
                  OP_GET: begin
                     if (hit_q) begin
                        cell_read_op = ONE << hit_idx_q;
                        rval_d = cell_value_out[
                           int'(hit_idx_q)*VALUE_WIDTH +: VALUE_WIDTH];
                     end else begin
                        status_d = ST_MISS;
                     end
                  end
                  OP_PUT: begin
                     cell_key_in   = key_q;
                     cell_value_in = value_q;
                     if (hit_q) begin
                        cell_write_op = ONE << hit_idx_q;
                     end else if (free_q) begin
                        cell_write_op = ONE << free_idx_q;
                     end else begin
`ifdef KV_CACHE_EVICT_EN
                        cell_write_op = ONE << victim_q;
                        evict         = 1'b1;
`else
                        cell_key_in   = '0;
                        cell_value_in = '0;
                        status_d      = ST_FULL;
`endif
                     end
                  end
                  default: begin
                     // DEL: an empty key/value pair frees the cell.
                     if (hit_q) cell_write_op = ONE << hit_idx_q;
                     else       status_d = ST_MISS;
                  end
               endcase
            end
         end
         default: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d  = S_IDLE;
               status_d = ST_OK;
               rval_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q       <= OP_GET;
         key_q      <= '0;
         value_q    <= '0;
         hit_q      <= 1'b0;
         free_q     <= 1'b0;
         hit_idx_q  <= '0;
         free_idx_q <= '0;
         status_q   <= ST_OK;
         rval_q     <= '0;
      end else begin
         if (accept) begin
            op_q    <= op_e'(cmd_op);
            key_q   <= cmd_key;
            value_q <= cmd_value;
         end
         if (state_q == S_LOOKUP) begin
            hit_q      <= hit_any;
            free_q     <= free_any;
            hit_idx_q  <= hit_idx;
            free_idx_q <= free_idx;
         end
         status_q <= status_d;
         rval_q   <= rval_d;
      end
   end

`ifdef KV_CACHE_EVICT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         victim_q <= '0;
      end else if (evict) begin
         if (victim_q == IW'(NUM_CELLS - 1)) victim_q <= '0;
         else                                victim_q <= victim_q + 1'b1;
      end
   end
`endif

   assign rsp_status = status_q;
   assign rsp_value  = rval_q;

endmodule

// File: doc/kv_cache_controller.md
Name: kv_cache_controller

Overview:
- Command front-end for the key/value store; sits directly upstream of the array of NUM_CELLS memory cells.
- Accepts GET/PUT/DEL commands over a valid/ready handshake and compares the command key against every cell in parallel.
- Drives the per-cell write/read strobes and returns the status and value over a response handshake.
- Key value 0 is reserved to mean "empty"; a cell is used when its stored key is non-zero.

Parameters:
- NUM_CELLS, 4, number of memory cells controlled (must be ≥2).
- KEY_WIDTH, 8, key width in bits.
- VALUE_WIDTH, 64, value width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  0=GET, 1=PUT, 2=DEL, 3=reserved
- cmd_key  in  KEY_WIDTH  command key
- cmd_value  in  VALUE_WIDTH  PUT data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_status  out  2  0=OK, 1=MISS, 2=FULL, 3=ERR
- rsp_value  out  VALUE_WIDTH  GET data; 0 otherwise
- cell_write_op  out  NUM_CELLS  per-cell write strobe
- cell_read_op  out  NUM_CELLS  per-cell read/select strobe
- cell_key_in  out  KEY_WIDTH  shared write key to the cells
- cell_value_in  out  VALUE_WIDTH  shared write value to the cells
- cell_key_out  in  NUM_CELLS*KEY_WIDTH  flattened stored keys; cell i occupies bits [i*KEY_WIDTH +: KEY_WIDTH]
- cell_value_out  in  NUM_CELLS*VALUE_WIDTH  flattened stored values
- cell_used  in  NUM_CELLS  per-cell used flag

Behaviour:
- Reset (synchronous, rst_n low at a clk edge): state=IDLE.
  - All outputs are 0, except cmd_ready=1.
  - An operation in progress is abandoned: no further cell strobes and no response.
- FSM state IDLE:
  - cmd_ready=1.
  - cmd_valid&&cmd_ready latches op/key/value, then go to LOOKUP.
- FSM state LOOKUP (1 cycle):
  - cell_read_op all ones.
  - hit_vec[i] = cell_used[i] && key_i==latched key.
  - free_vec = ~cell_used.
  - Register hit (any bit), hit_idx (lowest set index), free (any), free_idx (lowest set index).
  - Go to EXEC.
- FSM state EXEC (1 cycle); exactly one cell strobed, or none:
  - GET hit: cell_read_op one-hot at hit_idx; capture that cell's value into rsp_value; status OK.
  - GET miss: rsp_value=0; status MISS.
  - PUT hit: write cmd key/value at hit_idx (overwrite in place); status OK.
  - PUT miss, free available: write at free_idx; status OK.
  - PUT miss, no free cell: no write; status FULL.
  - DEL hit: write key 0, value 0 at hit_idx; status OK.
  - DEL miss: status MISS.
  - op==3, or latched key==0 (any op): no strobe; status ERR.
  - Go to RESP.
- FSM state RESP:
  - rsp_valid=1; rsp_status/rsp_value held stable.
  - Leave on rsp_valid&&rsp_ready, back to IDLE; cmd_ready returns to 1 in the following cycle.
- Latency: command accept edge to rsp_valid high is 3 cycles; throughput is at most one command per 4 cycles.
- cmd_ready=0 in LOOKUP, EXEC and RESP.
- cell_write_op and cell_read_op are never both non-zero in EXEC.
- cell_key_in and cell_value_in are 0 whenever no write is strobed.
- Multiple matching cells (illegal store state): the lowest index wins.

Optional Feature:
- Macro: KV_CACHE_EVICT_EN.
- Defined: PUT miss with no free cell overwrites cell victim_ptr and returns status OK.
  - victim_ptr is a $clog2(NUM_CELLS)-bit round-robin counter; reset value 0.
  - It increments only on an eviction and wraps from NUM_CELLS-1 to 0.
- Undefined: status FULL, no write, no victim_ptr logic.

Decomposition:
- Package kv_cache_pkg:
  - op_e (GET/PUT/DEL/RSVD).
  - status_e (OK/MISS/FULL/ERR).
  - state_e (IDLE/LOOKUP/EXEC/RESP).
  - Constant EMPTY_KEY = 0.
- One combinational sub-module, kv_match_encoder: takes a NUM_CELLS vector and returns any-set plus the lowest-set index.
  - Instantiated twice: once for hits, once for free cells.

Test Plan:
- PUT key 0x11/value 0xDEAD on empty store, then GET 0x11 -> cell_write_op=4'b0001; GET returns OK with rsp_value=0xDEAD; rsp_valid appears 3 cycles after accept.
- PUT 0x11=0x1 then PUT 0x11=0x2 -> second write strobes cell 0 again; GET 0x11 returns 0x2.
- Fill 4 cells with keys 1..4, then PUT key 5 -> without macro: FULL with no write strobe. With KV_CACHE_EVICT_EN: cell 0 overwritten, then cell 1 on the next eviction.
- DEL key 2 after fill, then GET 2 -> DEL returns OK with cell 1 written key 0/value 0; GET returns MISS with rsp_value=0. A later PUT 9 lands in cell 1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/status/value stay stable; cmd_ready stays 0; a new cmd_valid is not accepted.
- Assert rst_n=0 during EXEC; also send op=3 and key=0 -> reset: all strobes 0 next cycle and cmd_ready=1. Op=3 and key=0 each return ERR with no cell strobe.
